// File: rtl/bp_unit.sv
// bp_unit -- hardware breakpoint unit for a target core's code fetch port.
// NUM_BP comparators (exact / masked / range) watch tg_code_addr. A new match
// arms the unit; the target is halted on the next execute cycle by holding
// tg_code_ready low until resume. A level step request halts the same way.
// Optional feature: define BP_UNIT_PASS_COUNT_EN to add a per-breakpoint pass
// counter that lets a breakpoint be skipped COUNT times before it arms.
module bp_unit #(
  parameter int NUM_BP     = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  sysclk,
  input  logic                  sysreset_n,
  input  logic [ADDR_WIDTH-1:0] tg_code_addr,
  input  logic                  tg_enable_exec,
  input  logic                  rom_code_ready,
  input  logic                  step,
  input  logic                  resume,
  input  logic                  cfg_wr,
  input  logic [2:0]            cfg_idx,
  input  logic [1:0]            cfg_field,
  input  logic [ADDR_WIDTH-1:0] cfg_wdata,
  output logic [ADDR_WIDTH-1:0] cfg_rdata,
  output logic                  tg_code_ready,
  output logic                  bp_hit,
  output logic [2:0]            hit_id,
  output logic                  hit_step
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] FLD_ADDR  = 2'd0;
  localparam logic [1:0] FLD_AUX   = 2'd1;
  localparam logic [1:0] FLD_CTRL  = 2'd2;
  localparam logic [1:0] FLD_COUNT = 2'd3;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_EXACT  = 2'b01;
  localparam logic [1:0] MODE_MASKED = 2'b10;
  localparam logic [1:0] MODE_RANGE  = 2'b11;

  logic [ADDR_WIDTH-1:0] bp_addr [NUM_BP];
  logic [ADDR_WIDTH-1:0] bp_aux  [NUM_BP];
  logic [1:0]            bp_mode [NUM_BP];

  logic [NUM_BP-1:0]     cmp;
  logic [NUM_BP-1:0]     prev_cmp;
  logic [NUM_BP-1:0]     new_match;
  logic [NUM_BP-1:0]     arm;
  logic                  arm_any;
  logic [2:0]            arm_idx;
  logic [ADDR_WIDTH-1:0] prev_addr;
  logic [ADDR_WIDTH-1:0] halt_addr;
  logic                  suppress_q;
  logic                  match_en;
  logic                  reconfig;
  state_t                state;

  // A write that changes what a comparator looks for restarts the unit.
  assign reconfig = cfg_wr && (int'(cfg_idx) < NUM_BP) && (cfg_field != FLD_COUNT);

  // Matching only runs in RUN, and not while parked on the address we resumed at.
  assign match_en = (state == ST_RUN) && !(suppress_q && (tg_code_addr == halt_addr));

  // Configuration table: address, aux (mask / range high) and mode per breakpoint.
  // NOTE: non-blocking assignments in every clocked block so all registers sample pre-edge values.
  // NOTE: the table is a handful of flops, not RAM, and must come up disabled, so it is reset.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      for (int i = 0; i < NUM_BP; i++) begin
        bp_addr[i] <= '0;
        bp_aux[i]  <= '0;
        bp_mode[i] <= MODE_OFF;
      end
    end else if (cfg_wr) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (cfg_idx == 3'(i)) begin
          case (cfg_field)
            FLD_ADDR: bp_addr[i] <= cfg_wdata;
            FLD_AUX:  bp_aux[i]  <= cfg_wdata;
            FLD_CTRL: bp_mode[i] <= cfg_wdata[1:0];
            default:  ;
          endcase
        end
      end
    end
  end

  // Comparators and new-match detection (address changed or comparator just rose).
  // NOTE: every output gets a default before the loop so no path infers a latch.
  always_comb begin
    cmp       = '0;
    new_match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      case (bp_mode[i])
        MODE_EXACT:  cmp[i] = (tg_code_addr == bp_addr[i]);
        MODE_MASKED: cmp[i] = (((tg_code_addr ^ bp_addr[i]) & ~bp_aux[i]) == '0);
        MODE_RANGE:  cmp[i] = (tg_code_addr >= bp_addr[i]) && (tg_code_addr <= bp_aux[i]);
        default:     cmp[i] = 1'b0;
      endcase
      new_match[i] = match_en && cmp[i] && ((tg_code_addr != prev_addr) || !prev_cmp[i]);
    end
  end

`ifdef BP_UNIT_PASS_COUNT_EN
  logic [CNT_WIDTH-1:0] bp_count [NUM_BP];

  // Pass counters: each new match consumes one pass; a direct write beats the decrement.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      for (int i = 0; i < NUM_BP; i++) bp_count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (cfg_wr && (cfg_idx == 3'(i)) && (cfg_field == FLD_COUNT))
          bp_count[i] <= cfg_wdata[CNT_WIDTH-1:0];
        else if (new_match[i] && (bp_count[i] != '0))
          bp_count[i] <= bp_count[i] - 1'b1;
      end
    end
  end

  // A breakpoint arms only once its passes are used up.
  always_comb begin
    arm = '0;
    for (int i = 0; i < NUM_BP; i++) arm[i] = new_match[i] && (bp_count[i] == '0);
  end
`else
  localparam logic [CNT_WIDTH-1:0] COUNT_NONE = '0;

  // Without pass counters every new match arms.
  always_comb begin
    arm = new_match;
  end
`endif

  assign arm_any = |arm;

  // Lowest-numbered arming breakpoint wins.
  always_comb begin
    arm_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (arm[i]) arm_idx = 3'(i);
    end
  end

  // History for new-match detection.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      prev_addr <= '0;
      prev_cmp  <= '0;
    end else begin
      prev_addr <= tg_code_addr;
      prev_cmp  <= cmp;
    end
  end

  // Halt controller: RUN -> ARMED -> HALTED -> RUN, with registered halt outputs.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state      <= ST_RUN;
      bp_hit     <= 1'b0;
      hit_id     <= '0;
      hit_step   <= 1'b0;
      suppress_q <= 1'b0;
      halt_addr  <= '0;
    end else if (reconfig) begin
      state      <= ST_RUN;
      bp_hit     <= 1'b0;
      suppress_q <= 1'b0;
    end else begin
      if (suppress_q && (tg_code_addr != halt_addr)) suppress_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (arm_any || step) begin
            hit_id   <= arm_any ? arm_idx : 3'd0;
            hit_step <= ~arm_any;
            if (tg_enable_exec) begin
              state     <= ST_HALTED;
              bp_hit    <= 1'b1;
              halt_addr <= tg_code_addr;
            end else begin
              state <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (tg_enable_exec) begin
            state     <= ST_HALTED;
            bp_hit    <= 1'b1;
            halt_addr <= tg_code_addr;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state      <= ST_RUN;
            bp_hit     <= 1'b0;
            suppress_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_RUN;
          bp_hit <= 1'b0;
        end
      endcase
    end
  end

  assign tg_code_ready = rom_code_ready & ~bp_hit;

  // Configuration readback, zero-extended; unused indices read 0.
  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (cfg_idx == 3'(i)) begin
        case (cfg_field)
          FLD_ADDR: cfg_rdata = bp_addr[i];
          FLD_AUX:  cfg_rdata = bp_aux[i];
          FLD_CTRL: cfg_rdata = ADDR_WIDTH'(bp_mode[i]);
`ifdef BP_UNIT_PASS_COUNT_EN
          default:  cfg_rdata = ADDR_WIDTH'(bp_count[i]);
`else
          default:  cfg_rdata = ADDR_WIDTH'(COUNT_NONE);
`endif
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bp_unit.sv
// tb_bp_unit -- directed scenarios plus randomized traffic for bp_unit,
// checked every cycle against a behavioural model of the breakpoint rules.
module tb_bp_unit;

  localparam int NUM_BP = 4;
  localparam int AW     = 16;
  localparam int CW     = 8;

`ifdef BP_UNIT_PASS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          sysclk = 1'b0;
  logic          sysreset_n;
  logic [AW-1:0] tg_code_addr;
  logic          tg_enable_exec;
  logic          rom_code_ready;
  logic          step;
  logic          resume;
  logic          cfg_wr;
  logic [2:0]    cfg_idx;
  logic [1:0]    cfg_field;
  logic [AW-1:0] cfg_wdata;
  logic [AW-1:0] cfg_rdata;
  logic          tg_code_ready;
  logic          bp_hit;
  logic [2:0]    hit_id;
  logic          hit_step;

  bp_unit #(.NUM_BP(NUM_BP), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .sysclk         (sysclk),
    .sysreset_n     (sysreset_n),
    .tg_code_addr   (tg_code_addr),
    .tg_enable_exec (tg_enable_exec),
    .rom_code_ready (rom_code_ready),
    .step           (step),
    .resume         (resume),
    .cfg_wr         (cfg_wr),
    .cfg_idx        (cfg_idx),
    .cfg_field      (cfg_field),
    .cfg_wdata      (cfg_wdata),
    .cfg_rdata      (cfg_rdata),
    .tg_code_ready  (tg_code_ready),
    .bp_hit         (bp_hit),
    .hit_id         (hit_id),
    .hit_step       (hit_step)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_addr [8];
  int m_aux  [8];
  int m_mode [8];
  int m_cnt  [8];
  bit m_prev_hit [8];
  int m_prev_addr, m_halt_addr, m_hit_id;
  bit m_armed, m_halted, m_hit_step, m_sup;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_addr[i] = 0; m_aux[i] = 0; m_mode[i] = 0; m_cnt[i] = 0; m_prev_hit[i] = 0;
    end
    m_prev_addr = 0; m_halt_addr = 0; m_hit_id = 0;
    m_armed = 0; m_halted = 0; m_hit_step = 0; m_sup = 0;
  endtask

  function automatic bit m_match(int i, int a);
    case (m_mode[i])
      1:       return a == m_addr[i];
      2:       return ((a ^ m_addr[i]) & (~m_aux[i]) & 32'hFFFF) == 0;
      3:       return (a >= m_addr[i]) && (a <= m_aux[i]);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_read(int idx, int f);
    if (idx >= NUM_BP) return 0;
    case (f)
      0:       return m_addr[idx];
      1:       return m_aux[idx];
      2:       return m_mode[idx];
      default: return CNT_EN ? m_cnt[idx] : 0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic m_step();
    int a, first, idx, f, d;
    bit now [8];
    bit running, live, reconf;
    if (!sysreset_n) begin
      m_reset();
      return;
    end
    a = int'(tg_code_addr);
    idx = int'(cfg_idx);
    f = int'(cfg_field);
    d = int'(cfg_wdata);
    for (int i = 0; i < NUM_BP; i++) now[i] = m_match(i, a);
    running = !m_armed && !m_halted;
    live = running && !(m_sup && a == m_halt_addr);
    reconf = cfg_wr && idx < NUM_BP && f != 3;
    first = -1;
    for (int i = 0; i < NUM_BP; i++) begin
      if (live && now[i] && (a != m_prev_addr || !m_prev_hit[i])) begin
        if (CNT_EN && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        else if (first < 0) first = i;
      end
    end
    if (cfg_wr && idx < NUM_BP) begin
      case (f)
        0: m_addr[idx] = d;
        1: m_aux[idx]  = d;
        2: m_mode[idx] = d & 3;
        default: if (CNT_EN) m_cnt[idx] = d & ((1 << CW) - 1);
      endcase
    end
    if (reconf) begin
      m_armed = 0; m_halted = 0; m_sup = 0;
    end else begin
      if (m_sup && a != m_halt_addr) m_sup = 0;
      if (running && (first >= 0 || step)) begin
        m_hit_id   = (first >= 0) ? first : 0;
        m_hit_step = (first < 0);
        if (tg_enable_exec) begin m_halted = 1; m_halt_addr = a; end
        else m_armed = 1;
      end else if (m_armed && tg_enable_exec) begin
        m_armed = 0; m_halted = 1; m_halt_addr = a;
      end else if (m_halted && resume) begin
        m_halted = 0; m_sup = 1;
      end
    end
    m_prev_addr = a;
    for (int i = 0; i < NUM_BP; i++) m_prev_hit[i] = now[i];
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge sysclk) begin
    #2;
    if (cmp_en) begin
      check("bp_hit",        bp_hit,        m_halted);
      check("tg_code_ready", tg_code_ready, rom_code_ready && !m_halted);
      check("hit_id",        hit_id,        m_hit_id);
      check("hit_step",      hit_step,      m_hit_step);
      check("cfg_rdata",     cfg_rdata,     m_read(int'(cfg_idx), int'(cfg_field)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge sysclk);
    m_step();
    @(negedge sysclk);
  endtask

  task automatic cfg_write(input int idx, input int f, input int d);
    cfg_wr = 1'b1;
    cfg_idx = 3'(idx);
    cfg_field = 2'(f);
    cfg_wdata = 16'(d);
    tick();
    cfg_wr = 1'b0;
  endtask

  initial begin
    tg_code_addr = '0; tg_enable_exec = 0; rom_code_ready = 1; step = 0; resume = 0;
    cfg_wr = 0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
    sysreset_n = 1'b0;
    m_reset();
    cmp_en = 1'b1;
    tick(); tick();
    sysreset_n = 1'b1;
    #3;
    check("rst_bp_hit", bp_hit, 0);
    check("rst_hit_id", hit_id, 0);
    check("rst_hit_step", hit_step, 0);
    check("rst_ready", tg_code_ready, 1);

    // Exact breakpoint armed on a non-execute cycle, halts on the execute cycle.
    cfg_write(0, 0, 'h40);
    cfg_write(0, 2, 1);
    tg_code_addr = 16'h0040; tg_enable_exec = 0;
    tick(); #3;
    check("exact_armed_no_hit", bp_hit, 0);
    tick();
    tg_enable_exec = 1;
    tick(); #3;
    check("exact_hit", bp_hit, 1);
    check("exact_hit_id", hit_id, 0);
    check("exact_ready_low", tg_code_ready, 0);

    // Resume on the same address must not re-hit; leaving and returning does.
    resume = 1; tick(); resume = 0; #3;
    check("resume_release", bp_hit, 0);
    tick(); tick(); #3;
    check("resume_no_rehit", bp_hit, 0);
    tg_code_addr = 16'h0041; tick();
    tg_code_addr = 16'h0040; tick(); #3;
    check("rehit", bp_hit, 1);

    // CTRL write while halted releases; step halts with hit_step.
    cfg_write(0, 2, 0); #3;
    check("ctrl_wr_release", bp_hit, 0);
    tg_enable_exec = 0; step = 1; tick(); step = 0; #3;
    check("step_armed_no_hit", bp_hit, 0);
    check("step_latched", hit_step, 1);
    tg_enable_exec = 1; tick(); #3;
    check("step_hit", bp_hit, 1);
    check("step_hit_step", hit_step, 1);
    cfg_write(0, 2, 0); #3;
    check("step_ctrl_release", bp_hit, 0);

    // Range and masked both match; lowest index wins, same-edge halt.
    cfg_write(1, 0, 'h100); cfg_write(1, 1, 'h1FF); cfg_write(1, 2, 3);
    cfg_write(2, 0, 'h120); cfg_write(2, 1, 'h00F); cfg_write(2, 2, 2);
    tg_code_addr = 16'h0125; tg_enable_exec = 1;
    tick(); #3;
    check("range_hit", bp_hit, 1);
    check("range_hit_id", hit_id, 1);
    check("range_hit_step", hit_step, 0);
    cfg_write(1, 2, 0); cfg_write(2, 2, 0);

    // Pass count: halt only on the third visit.
    tg_code_addr = 16'h0000;
    cfg_write(0, 0, 'h10); cfg_write(0, 3, 2); cfg_write(0, 2, 1);
    cfg_idx = 3'd0; cfg_field = 2'd3;
    tg_code_addr = 16'h0010; tick(); #3;
`ifdef BP_UNIT_PASS_COUNT_EN
    check("cnt_visit1_hit", bp_hit, 0);
    check("cnt_visit1_cnt", cfg_rdata, 1);
    tg_code_addr = 16'h0011; tick();
    tg_code_addr = 16'h0010; tick(); #3;
    check("cnt_visit2_hit", bp_hit, 0);
    check("cnt_visit2_cnt", cfg_rdata, 0);
    tg_code_addr = 16'h0012; tick();
    tg_code_addr = 16'h0010; tick(); #3;
    check("cnt_visit3_hit", bp_hit, 1);
    check("cnt_visit3_cnt", cfg_rdata, 0);
`else
    check("nocnt_visit1_hit", bp_hit, 1);
    check("nocnt_cnt_reads0", cfg_rdata, 0);
`endif

    // Reset while halted: release immediately and clear the table.
    rom_code_ready = 1;
    sysreset_n = 1'b0;
    m_reset();
    #3;
    check("rst_halt_bp_hit", bp_hit, 0);
    check("rst_halt_ready", tg_code_ready, 1);
    check("rst_halt_hit_id", hit_id, 0);
    for (int f = 0; f < 4; f++) begin
      tick();
      cfg_idx = (f == 3) ? 3'd0 : 3'd1;
      cfg_field = 2'(f);
      #3;
      check("rst_rdata_zero", cfg_rdata, 0);
    end
    tick();
    sysreset_n = 1'b1;

    // Randomized traffic on a small address window so comparators fire often.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 1) tg_code_addr = 16'($urandom_range(0, 31));
      tg_enable_exec = ($urandom_range(0, 1) == 1);
      rom_code_ready = ($urandom_range(0, 3) != 0);
      step   = ($urandom_range(0, 15) == 0);
      resume = ($urandom_range(0, 3) == 0);
      cfg_wr = ($urandom_range(0, 19) == 0);
      cfg_idx = 3'($urandom_range(0, 7));
      cfg_field = 2'($urandom_range(0, 3));
      cfg_wdata = (cfg_field == 2'd3) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 31));
      tick();
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_unit.md
BP_UNIT -- requirements
Module: bp_unit

Interface
REQ-001 Parameter NUM_BP, default 4 (legal 1..8); number of breakpoint comparators.
REQ-002 Parameter ADDR_WIDTH, default 16; width of the target code address.
REQ-003 Parameter CNT_WIDTH, default 8; width of each per-breakpoint pass counter.
REQ-004 sysclk  in  1  sole clock; all state on rising edge.
REQ-005 sysreset_n  in  1  asynchronous, active-low reset.
REQ-006 tg_code_addr  in  ADDR_WIDTH  target fetch address.
REQ-007 tg_enable_exec  in  1  target is in an ordinary assignment (execute) cycle.
REQ-008 rom_code_ready  in  1  ROM ready, passed through when not halted.
REQ-009 step  in  1  level; single-step request.
REQ-010 resume  in  1  one-cycle pulse; leave HALTED.
REQ-011 cfg_wr  in  1  write strobe for configuration field.
REQ-012 cfg_idx  in  3  breakpoint index; indices >= NUM_BP ignored on write, read 0.
REQ-013 cfg_field  in  2  0 = ADDR, 1 = AUX (mask or range high), 2 = CTRL (mode[1:0]), 3 = COUNT.
REQ-014 cfg_wdata  in  ADDR_WIDTH  write data; COUNT uses low CNT_WIDTH bits, CTRL uses bits[1:0].
REQ-015 cfg_rdata  out  ADDR_WIDTH  combinational readback of the selected field, zero-extended.
REQ-016 tg_code_ready  out  1  rom_code_ready AND NOT bp_hit.
REQ-017 bp_hit  out  1  high while in HALTED.
REQ-018 hit_id  out  3  index of breakpoint that caused the halt.
REQ-019 hit_step  out  1  halt caused by step, not by a comparator.

Function
REQ-020 Modes per breakpoint: 00 disabled; 01 exact (addr == ADDR); 10 masked ((addr ^ ADDR) & ~AUX == 0); 11 range (ADDR <= addr <= AUX, unsigned); range with ADDR > AUX never matches.
REQ-021 A new match for breakpoint i occurs when its comparator is true AND (tg_code_addr differs from the previous cycle's address OR the previous cycle's comparator was false).
REQ-022 Per new match: if COUNT[i] != 0, COUNT[i] decrements by 1 and the breakpoint does not arm; if COUNT[i] == 0, it arms. Count saturates at 0.
REQ-023 States: RUN, ARMED, HALTED.
REQ-024 RUN -> ARMED on arming (REQ-022) or step, when tg_enable_exec = 0 that cycle; RUN -> HALTED directly when tg_enable_exec = 1 that cycle.
REQ-025 ARMED -> HALTED on the next cycle with tg_enable_exec = 1.
REQ-026 HALTED -> RUN on resume; bp_hit falls the cycle after resume is sampled.
REQ-027 hit_id and hit_step latch at the arming event and hold until the next arming event; lowest index wins on multiple simultaneous arms; a comparator arm beats step (hit_step = 0).
REQ-028 After resume, comparator matching is suppressed until tg_code_addr differs from the address latched at HALTED entry; step is not suppressed.
REQ-029 Any cfg_wr to field ADDR, AUX or CTRL forces state to RUN and clears suppression, taking priority over all other transitions that cycle; COUNT writes do not alter state.
REQ-030 cfg_wr to COUNT in the same cycle as a decrement of that breakpoint: the write wins.
REQ-031 No new matches or count decrements are evaluated while in ARMED or HALTED.

Reset
REQ-032 On sysreset_n low, asynchronously: state RUN, bp_hit 0, hit_id 0, hit_step 0, all ADDR/AUX/COUNT 0, all CTRL 00 (disabled), suppression cleared, previous-address register 0.
REQ-033 Reset mid-HALTED releases tg_code_ready immediately (follows rom_code_ready).

Configuration
REQ-034 Macro BP_UNIT_PASS_COUNT_EN: when defined, COUNT registers and REQ-022 decrement exist; when undefined, no COUNT storage, COUNT writes ignored, COUNT reads 0, every new match arms.

Verification
REQ-035 Bp0 exact 0x0040, addr 0x0040 with tg_enable_exec=0 for 2 cycles then 1 -> ARMED then bp_hit=1, hit_id=0, tg_code_ready=0.
REQ-036 Bp1 range 0x0100..0x01FF, bp2 masked ADDR 0x0120 AUX 0x000F, addr 0x0125 with exec=1 -> halt same-edge, hit_id=1.
REQ-037 Bp0 exact 0x0010, COUNT=2, address visits 0x0010 three times (with other addresses between) -> halt only on third visit; COUNT reads 0 (with BP_UNIT_PASS_COUNT_EN).
REQ-038 Halted at 0x0040, resume while addr stays 0x0040 -> no re-hit; addr -> 0x0041 -> 0x0040 -> re-hit.
REQ-039 step=1 with bp0 disabled, exec pulse -> bp_hit=1, hit_step=1; cfg_wr to CTRL while HALTED -> bp_hit=0 next cycle.
REQ-040 Assert sysreset_n low while HALTED -> bp_hit=0, tg_code_ready=rom_code_ready, cfg_rdata 0 for all fields.
